// File: rtl/param_load_sequencer_if.sv
// param_load_sequencer_if
//   Bundles the load sequencer's control, source-handshake, grid-write and
//   status signals. The sequencer connects through `master`; upstream sources,
//   the grid write side and any controller connect through `slave`.
//   Signals:
//     start                                  load request
//     inst_src_valid/data/ready              instruction source (2-bit entries)
//     param_src_valid/data/ready             parameter row source (368-bit rows)
//     neuron_inst_wdata/winc/wfull           grid instruction FIFO write side
//     parameter_in/param_winc/param_wfull    grid parameter FIFO write side
//     next_core, next_core_en                core select / grid acknowledgement
//     busy, done, error                      status
interface param_load_sequencer_if;
  logic         start;
  logic         inst_src_valid;
  logic [1:0]   inst_src_data;
  logic         inst_src_ready;
  logic         param_src_valid;
  logic [367:0] param_src_data;
  logic         param_src_ready;
  logic [1:0]   neuron_inst_wdata;
  logic         neuron_inst_winc;
  logic         neuron_inst_wfull;
  logic [367:0] parameter_in;
  logic         param_winc;
  logic         param_wfull;
  logic [2:0]   next_core;
  logic         next_core_en;
  logic         busy;
  logic         done;
  logic         error;

  modport master (
    input  start,
    input  inst_src_valid, inst_src_data, output inst_src_ready,
    input  param_src_valid, param_src_data, output param_src_ready,
    output neuron_inst_wdata, neuron_inst_winc, input neuron_inst_wfull,
    output parameter_in, param_winc, input param_wfull,
    output next_core, input next_core_en,
    output busy, done, error
  );

  modport slave (
    output start,
    output inst_src_valid, inst_src_data, input inst_src_ready,
    output param_src_valid, param_src_data, input param_src_ready,
    input  neuron_inst_wdata, neuron_inst_winc, output neuron_inst_wfull,
    input  parameter_in, param_winc, output param_wfull,
    input  next_core, output next_core_en,
    input  busy, done, error
  );
endinterface

// File: rtl/param_load_sequencer.sv
// param_load_sequencer
//   Sys-clock-side writer for the grid parameter / neuron-instruction load
//   path. Streams NUM_INST instruction entries once, then ROWS_PER_CORE
//   parameter rows for each of NUM_LOAD_CORES cores. After each core's rows it
//   waits for the grid to acknowledge (next_core_en seen low, then high)
//   before selecting the next core; a missing acknowledgement within
//   DRAIN_TIMEOUT cycles ends the load in ERROR.
//   Ports:
//     clk    sys clock (grid sys_clk domain)
//     reset  asynchronous, active-high
//     bus    param_load_sequencer_if.master (sources, grid writes, status)
module param_load_sequencer #(
  parameter int NUM_LOAD_CORES = 5,
  parameter int ROWS_PER_CORE  = 256,
  parameter int NUM_INST       = 256,
  parameter int DRAIN_TIMEOUT  = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  param_load_sequencer_if.master        bus
);
  localparam int IW = (NUM_INST      > 1) ? $clog2(NUM_INST)      : 1;
  localparam int RW = (ROWS_PER_CORE > 1) ? $clog2(ROWS_PER_CORE) : 1;
  localparam int TW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [IW-1:0] INST_LAST = IW'(NUM_INST - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS_PER_CORE - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(DRAIN_TIMEOUT - 1);
  localparam logic [2:0]    CORE_LAST = 3'(NUM_LOAD_CORES - 1);
  // Grid code for "all write-enables off".
  localparam logic [2:0]    CORE_NONE = 3'b111;

  typedef enum logic [2:0] {IDLE, INST, PARAM, DRAIN, DONE, ERROR} state_t;

  state_t        state, state_n;
  logic [IW-1:0] inst_cnt;
  logic [RW-1:0] row_cnt;
  logic [2:0]    core_idx;
  logic [TW-1:0] tmo_cnt;
  logic          seen_low;
  logic          done_q, error_q;
  logic          inst_fire, row_fire, ack, restart, in_core;

  // Write handshakes are purely combinational so a stream moves one beat per
  // cycle with no bubbles.
  assign bus.inst_src_ready    = (state == INST)  & ~bus.neuron_inst_wfull;
  assign bus.param_src_ready   = (state == PARAM) & ~bus.param_wfull;
  assign inst_fire             = bus.inst_src_ready  & bus.inst_src_valid;
  assign row_fire              = bus.param_src_ready & bus.param_src_valid;
  assign bus.neuron_inst_winc  = inst_fire;
  assign bus.param_winc        = row_fire;
  assign bus.neuron_inst_wdata = bus.inst_src_data;
  assign bus.parameter_in      = bus.param_src_data;

  assign in_core  = (state == PARAM) | (state == DRAIN);
  // next_core_en is also high before the grid consumed anything, so it only
  // counts as an acknowledgement after it has been seen low for this core.
  assign ack      = (state == DRAIN) & seen_low & bus.next_core_en;
  assign restart  = bus.start & ((state == IDLE) | (state == DONE) | (state == ERROR));

  assign bus.next_core = in_core ? core_idx : CORE_NONE;
  assign bus.busy      = (state == INST) | in_core;
  assign bus.done      = done_q;
  assign bus.error     = error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE, ERROR: if (bus.start) state_n = INST;
      INST:  if (inst_fire && inst_cnt == INST_LAST) state_n = PARAM;
      PARAM: if (row_fire && row_cnt == ROW_LAST)    state_n = DRAIN;
      DRAIN: begin
        if (ack)                      state_n = (core_idx == CORE_LAST) ? DONE : PARAM;
        else if (tmo_cnt == TMO_LAST) state_n = ERROR;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_cnt <= '0;
      row_cnt  <= '0;
      core_idx <= '0;
      tmo_cnt  <= '0;
      seen_low <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else if (restart) begin
      inst_cnt <= '0;
      row_cnt  <= '0;
      core_idx <= '0;
      tmo_cnt  <= '0;
      seen_low <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      // Set whenever the grid address is seen off 0 for the current core;
      // cleared below on the acknowledgement, which needs next_core_en high,
      // so the two never collide.
      if (in_core && !bus.next_core_en) seen_low <= 1'b1;
      unique case (state)
        INST: if (inst_fire) begin
          // Terminal compare holds the counter instead of wrapping.
          if (inst_cnt == INST_LAST) core_idx <= '0;
          else                       inst_cnt <= inst_cnt + 1'b1;
        end
        PARAM: if (row_fire) begin
          if (row_cnt == ROW_LAST) begin
            row_cnt <= '0;
            tmo_cnt <= '0;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (ack) begin
            if (core_idx == CORE_LAST) begin
              done_q <= 1'b1;
            end else begin
              core_idx <= core_idx + 1'b1;
              seen_low <= 1'b0;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            error_q <= 1'b1;   // counter saturates here
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_param_load_sequencer.sv
module tb_param_load_sequencer;
  localparam int NC   = 5;
  localparam int ROWS = 256;
  localparam int NI   = 256;
  localparam int TMO  = 4096;

  localparam int PH_IDLE = 0, PH_INST = 1, PH_PARAM = 2, PH_DRAIN = 3, PH_DONE = 4, PH_ERR = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_load_sequencer_if bus();

  param_load_sequencer #(
    .NUM_LOAD_CORES(NC), .ROWS_PER_CORE(ROWS), .NUM_INST(NI), .DRAIN_TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [367:0] act, input logic [367:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] inst_pat(input int k);
    return 2'(k ^ (k >> 3));
  endfunction

  function automatic logic [367:0] param_pat(input int c, input int r);
    logic [31:0] w;
    w = 32'(c * ROWS + r) * 32'h9E3779B1;
    return {8'(c), 8'(r), {11{w}}};
  endfunction

  // stimulus controls, written only by the main sequence
  int inst_gap = 0;
  bit wfull_mode = 0;
  bit en_mode = 0;

  // ---------------- instruction source ----------------
  int  ik, icyc;
  bit  i_fire, i_rst;
  initial begin
    ik = 0; icyc = 0;
    bus.inst_src_valid = 1'b0;
    bus.inst_src_data  = '0;
    forever begin
      @(negedge clk);
      i_fire = bus.inst_src_valid && bus.inst_src_ready;
      i_rst  = reset || (bus.start && !bus.busy);
      @(posedge clk); #1;
      if (i_rst) begin ik = 0; icyc = 0; end
      else if (i_fire) ik++;
      icyc++;
      bus.inst_src_valid = (inst_gap == 0) || (icyc % (inst_gap + 1) == 0);
      bus.inst_src_data  = inst_pat(ik);
    end
  end

  // ---------------- parameter source ----------------
  int pk;
  bit p_fire, p_rst;
  initial begin
    pk = 0;
    bus.param_src_valid = 1'b1;
    bus.param_src_data  = param_pat(0, 0);
    forever begin
      @(negedge clk);
      p_fire = bus.param_src_valid && bus.param_src_ready;
      p_rst  = reset || (bus.start && !bus.busy);
      @(posedge clk); #1;
      if (p_rst) pk = 0;
      else if (p_fire) pk++;
      bus.param_src_data = param_pat(pk / ROWS, pk % ROWS);
    end
  end

  // ---------------- grid model: acknowledgement and FIFO full ----------------
  int g_rows, g_dly, g_cyc;
  bit g_fire, g_rst;
  initial begin
    g_rows = 0; g_dly = 0; g_cyc = 0;
    bus.next_core_en      = 1'b0;
    bus.param_wfull       = 1'b0;
    bus.neuron_inst_wfull = 1'b0;
    forever begin
      @(negedge clk);
      g_fire = bus.param_winc;
      g_rst  = reset || (bus.start && !bus.busy);
      @(posedge clk); #1;
      g_cyc++;
      if (g_rst) begin g_rows = 0; g_dly = 0; end
      else if (g_fire) begin
        g_rows++;
        if (g_rows % ROWS == 0) g_dly = 10;
      end
      if (en_mode) bus.next_core_en = 1'b1;
      else begin
        if (g_rst || g_fire) bus.next_core_en = 1'b0;   // address leaves 0
        if (g_dly > 0) begin
          g_dly--;
          if (g_dly == 0) bus.next_core_en = 1'b1;
        end
      end
      bus.param_wfull = wfull_mode && g_rows >= 2 * ROWS && g_rows < 3 * ROWS && ((g_cyc / 3) % 2 == 1);
    end
  end

  // ---------------- monitor: independent tallies ----------------
  int inst_wr, par_wr, core2_wr, drain_cyc, inst_at_p0;
  logic [2:0] nc_prev;
  logic [2:0] nc_seq[$];
  always @(negedge clk) begin
    if (reset || (bus.start && !bus.busy)) begin
      inst_wr = 0; par_wr = 0; core2_wr = 0; drain_cyc = 0; inst_at_p0 = -1;
      nc_prev = 3'd7; nc_seq.delete();
    end else begin
      if (bus.neuron_inst_winc) inst_wr++;
      if (bus.busy && par_wr == ROWS) drain_cyc++;
      if (bus.param_winc) begin
        if (par_wr == 0) inst_at_p0 = inst_wr;
        if (bus.next_core == 3'd2) core2_wr++;
        par_wr++;
      end
      if (bus.next_core != nc_prev) begin
        nc_seq.push_back(bus.next_core);
        nc_prev = bus.next_core;
      end
    end
  end

  function automatic logic [17:0] seq_pack();
    logic [17:0] v;
    v = '0;
    foreach (nc_seq[i]) v = {v[14:0], nc_seq[i]};
    return v;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  int m_ph = PH_IDLE, m_inst, m_row, m_core, m_wait, old_ph;
  bit m_seen, m_done, m_err, m_ack, e_ir, e_pr, e_iw, e_pw;
  always @(negedge clk) begin
    if (reset) begin
      m_ph = PH_IDLE; m_inst = 0; m_row = 0; m_core = 0; m_wait = 0;
      m_seen = 0; m_done = 0; m_err = 0;
      chk("rst_next_core", bus.next_core, 3'd7);
      chk("rst_inst_ready", bus.inst_src_ready, 1'b0);
      chk("rst_param_ready", bus.param_src_ready, 1'b0);
      chk("rst_inst_winc", bus.neuron_inst_winc, 1'b0);
      chk("rst_param_winc", bus.param_winc, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, 1'b0);
      chk("rst_error", bus.error, 1'b0);
    end else begin
      e_ir = (m_ph == PH_INST)  && !bus.neuron_inst_wfull;
      e_pr = (m_ph == PH_PARAM) && !bus.param_wfull;
      e_iw = e_ir && bus.inst_src_valid;
      e_pw = e_pr && bus.param_src_valid;
      chk("inst_ready", bus.inst_src_ready, e_ir);
      chk("inst_winc", bus.neuron_inst_winc, e_iw);
      chk("param_ready", bus.param_src_ready, e_pr);
      chk("param_winc", bus.param_winc, e_pw);
      if (e_iw) chk("inst_wdata", bus.neuron_inst_wdata, inst_pat(m_inst));
      if (e_pw) chk("param_data", bus.parameter_in, param_pat(m_core, m_row));
      chk("next_core", bus.next_core,
          (m_ph == PH_PARAM || m_ph == PH_DRAIN) ? 3'(m_core) : 3'd7);
      chk("busy", bus.busy, m_ph == PH_INST || m_ph == PH_PARAM || m_ph == PH_DRAIN);
      chk("done", bus.done, m_done);
      chk("error", bus.error, m_err);

      old_ph = m_ph;
      m_ack = 0;
      case (m_ph)
        PH_IDLE, PH_DONE, PH_ERR: if (bus.start) begin
          m_ph = PH_INST; m_inst = 0; m_row = 0; m_core = 0; m_wait = 0;
          m_seen = 0; m_done = 0; m_err = 0;
        end
        PH_INST: if (e_iw) begin
          m_inst++;
          if (m_inst == NI) begin m_ph = PH_PARAM; m_core = 0; m_row = 0; end
        end
        PH_PARAM: if (e_pw) begin
          m_row++;
          if (m_row == ROWS) begin m_ph = PH_DRAIN; m_row = 0; m_wait = 0; end
        end
        PH_DRAIN: begin
          if (m_seen && bus.next_core_en) begin
            if (m_core == NC - 1) begin m_ph = PH_DONE; m_done = 1; end
            else begin m_core++; m_ph = PH_PARAM; m_ack = 1; end
          end else begin
            m_wait++;
            if (m_wait == TMO) begin m_ph = PH_ERR; m_err = 1; end
          end
        end
        default: ;
      endcase
      if ((old_ph == PH_PARAM || old_ph == PH_DRAIN) && !bus.next_core_en) m_seen = 1;
      if (m_ack) m_seen = 0;
    end
  end

  // ---------------- directed sequence ----------------
  task automatic do_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
  endtask

  task automatic wait_end(input int budget, input string name);
    int n;
    n = 0;
    while (!(bus.done || bus.error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < budget, 1'b1);
    @(negedge clk);
  endtask

  task automatic wait_par(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (par_wr < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, n < budget, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("init_next_core", bus.next_core, 3'd7);
    chk("init_busy", bus.busy, 1'b0);
    @(posedge clk); #1 reset = 1'b0;

    // A: clean full load
    do_start();
    wait_end(4000, "A_finished");
    chk("A_inst_writes", inst_wr, 256);
    chk("A_inst_before_param", inst_at_p0, 256);
    chk("A_param_writes", par_wr, 1280);
    chk("A_seq_len", nc_seq.size(), 6);
    chk("A_core_seq", seq_pack(), {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7});
    chk("A_done", bus.done, 1'b1);
    chk("A_busy", bus.busy, 1'b0);
    chk("A_error", bus.error, 1'b0);

    // B: instruction gaps, start during core 1, wfull toggling during core 2
    inst_gap = 5; wfull_mode = 1;
    do_start();
    wait_par(ROWS + 50, 4000, "B_reach_core1");
    chk("B_core1_sel", bus.next_core, 3'd1);
    do_start();
    @(negedge clk);
    chk("B_start_ignored_busy", bus.busy, 1'b1);
    chk("B_start_ignored_core", bus.next_core, 3'd1);
    wait_end(8000, "B_finished");
    chk("B_inst_writes", inst_wr, 256);
    chk("B_inst_before_param", inst_at_p0, 256);
    chk("B_core2_writes", core2_wr, 256);
    chk("B_param_writes", par_wr, 1280);
    chk("B_core_seq", seq_pack(), {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7});
    chk("B_done", bus.done, 1'b1);
    inst_gap = 0; wfull_mode = 0;

    // C: acknowledgement never low -> drain timeout
    en_mode = 1;
    do_start();
    wait_end(8000, "C_finished");
    chk("C_error", bus.error, 1'b1);
    chk("C_done", bus.done, 1'b0);
    chk("C_next_core", bus.next_core, 3'd7);
    chk("C_drain_cycles", drain_cyc, 4096);
    chk("C_param_writes", par_wr, 256);
    en_mode = 0;

    // D: reset mid-load at row 100 of core 3, then clean restart
    do_start();
    wait_par(3 * ROWS + 100, 4000, "D_reach_core3");
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("D_rst_next_core", bus.next_core, 3'd7);
    chk("D_rst_busy", bus.busy, 1'b0);
    chk("D_rst_error", bus.error, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    do_start();
    @(negedge clk);
    chk("D_inst_busy", bus.busy, 1'b1);
    chk("D_inst_next_core", bus.next_core, 3'd7);
    wait_end(4000, "D_finished");
    chk("D_inst_writes", inst_wr, 256);
    chk("D_param_writes", par_wr, 1280);
    chk("D_done", bus.done, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
